// File: rtl/branch_pkg.sv
// branch_pkg: branch opcodes, resolve FSM states and branch decode helper
package branch_pkg;
  localparam logic [3:0] OP_BEQ = 4'b1100;
  localparam logic [3:0] OP_BNE = 4'b1101;
  localparam logic [3:0] OP_BLT = 4'b1110;
  localparam logic [3:0] OP_BGE = 4'b1111;
  typedef enum logic {IDLE, REDIRECT} state_t;
  function automatic logic is_branch(input logic [3:0] op);
    return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE};
  endfunction
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: decodes branch ids and evaluates the condition from the ALU difference bits
module branch_cond_eval import branch_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0]  in_inst_id,
  input  logic [WIDTH-1:0] in_result,
  output logic             is_branch,
  output logic             taken
);
  always_comb begin
    is_branch = branch_pkg::is_branch(in_inst_id);
    taken = is_branch && (in_inst_id == OP_BEQ ? in_result == '0 :
                          in_inst_id == OP_BNE ? in_result != '0 :
                          in_inst_id == OP_BLT ? in_result[WIDTH-1] : !in_result[WIDTH-1]);
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves branches, offers a handshaked PC redirect with a one-cycle flush, keeps saturating stats
module branch_resolve_unit import branch_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int OP_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_inst_id,
  input  logic [WIDTH-1:0] in_result,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_offset,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);
  state_t state, state_nxt;
  logic is_br, taken, accept;
  branch_cond_eval #(.WIDTH(WIDTH), .OP_W(OP_W)) u_cond (
    .in_inst_id(in_inst_id),
    .in_result(in_result),
    .is_branch(is_br),
    .taken(taken)
  );
  always_comb begin
    in_ready = reset && state == IDLE;
    redirect_valid = state == REDIRECT;
    accept = in_valid && in_ready;
    state_nxt = state == IDLE ? (accept && taken ? REDIRECT : IDLE) : (redirect_ready ? IDLE : REDIRECT);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      redirect_pc <= '0;
      flush <= 1'b0;
      branch_count <= '0;
      taken_count <= '0;
    end else begin
      state <= state_nxt;
      flush <= accept && taken;
      if (accept && taken) redirect_pc <= in_pc + WIDTH'(1) + in_offset;
      if (accept && is_br && !(&branch_count)) branch_count <= branch_count + CNT_W'(1);
      if (accept && taken && !(&taken_count)) taken_count <= taken_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: scoreboard bench for branch resolution, redirect handshake, flush and saturating counters
module tb_branch_resolve_unit;
  localparam int W = 16;
  localparam int O = 4;
  localparam int C = 16;
  logic clk = 0, reset = 0, in_valid = 0, redirect_ready = 0;
  logic in_ready, redirect_valid, flush;
  logic [O-1:0] in_inst_id = '0;
  logic [W-1:0] in_result = '0, in_pc = '0, in_offset = '0, redirect_pc;
  logic [C-1:0] branch_count, taken_count;
  logic [W-1:0] exp_q[$];
  logic [C-1:0] exp_br = '0, exp_tk = '0;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  branch_resolve_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst_id(in_inst_id), .in_result(in_result), .in_pc(in_pc), .in_offset(in_offset),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready), .redirect_pc(redirect_pc),
    .flush(flush), .branch_count(branch_count), .taken_count(taken_count)
  );
  function automatic logic m_branch(input logic [3:0] id);
    return id[3:2] == 2'b11;
  endfunction
  function automatic logic m_taken(input logic [3:0] id, input logic [W-1:0] r);
    case (id)
      4'b1100: return r == 0;
      4'b1101: return r != 0;
      4'b1110: return r[W-1];
      4'b1111: return !r[W-1];
      default: return 1'b0;
    endcase
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [3:0] id, input logic [W-1:0] r, pc, off);
    logic tk;
    tk = m_taken(id, r);
    in_valid = 1; in_inst_id = id; in_result = r; in_pc = pc; in_offset = off;
    total++; if (in_ready !== 1'b1) $display("FAIL issue_ready got %b want 1", in_ready); else passed++;
    if (m_branch(id) && exp_br != '1) exp_br++;
    if (tk && exp_tk != '1) exp_tk++;
    if (tk) exp_q.push_back(pc + off + 16'd1);
    step();
    in_valid = 0;
    total++; if (flush !== tk) $display("FAIL issue_flush got %b want %b", flush, tk); else passed++;
    total++; if (redirect_valid !== tk) $display("FAIL issue_rvalid got %b want %b", redirect_valid, tk); else passed++;
    total++; if (branch_count !== exp_br) $display("FAIL branch_count got %h want %h", branch_count, exp_br); else passed++;
    total++; if (taken_count !== exp_tk) $display("FAIL taken_count got %h want %h", taken_count, exp_tk); else passed++;
  endtask
  task automatic drain(input int hold);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      total++; $display("FAIL drain_empty got 0 want >0 entries");
      return;
    end
    e = exp_q.pop_front();
    redirect_ready = 0;
    repeat (hold) begin
      step();
      total++; if (redirect_valid !== 1'b1 || in_ready !== 1'b0 || flush !== 1'b0)
        $display("FAIL hold_state got v=%b r=%b f=%b want 1 0 0", redirect_valid, in_ready, flush); else passed++;
      total++; if (redirect_pc !== e) $display("FAIL hold_pc got %h want %h", redirect_pc, e); else passed++;
    end
    redirect_ready = 1;
    total++; if (redirect_valid !== 1'b1 || redirect_pc !== e)
      $display("FAIL redirect got v=%b pc=%h want 1 %h", redirect_valid, redirect_pc, e); else passed++;
    step();
    redirect_ready = 0;
    total++; if (redirect_valid !== 1'b0 || in_ready !== 1'b1 || redirect_pc !== e)
      $display("FAIL post_redirect got v=%b r=%b pc=%h want 0 1 %h", redirect_valid, in_ready, redirect_pc, e); else passed++;
  endtask
  task automatic test_reset();
    reset = 0; in_valid = 1; in_inst_id = 4'b1100; in_result = '0; in_pc = 16'h0040; in_offset = 16'h0002;
    step();
    step();
    total++; if (redirect_valid !== 1'b0 || flush !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL reset_ctl got v=%b f=%b r=%b want 0 0 0", redirect_valid, flush, in_ready); else passed++;
    total++; if (branch_count !== '0 || taken_count !== '0 || redirect_pc !== '0)
      $display("FAIL reset_regs got %h %h %h want 0 0 0", branch_count, taken_count, redirect_pc); else passed++;
    in_valid = 0; reset = 1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_release got %b want 1", in_ready); else passed++;
  endtask
  task automatic test_beq();
    issue(4'b1100, 16'h0000, 16'h0010, 16'h0004);
    total++; if (redirect_pc !== 16'h0015) $display("FAIL beq_pc got %h want 0015", redirect_pc); else passed++;
    drain(3);
  endtask
  task automatic test_bne();
    issue(4'b1101, 16'h0000, 16'h0020, 16'h0008);
    total++; if (in_ready !== 1'b1) $display("FAIL bne_ready got %b want 1", in_ready); else passed++;
    issue(4'b1101, 16'h0003, 16'h0030, 16'h0010);
    drain(0);
  endtask
  task automatic test_blt_bge();
    issue(4'b1110, 16'h8000, 16'h0002, 16'hFFFC);
    total++; if (redirect_pc !== 16'hFFFF) $display("FAIL blt_wrap got %h want ffff", redirect_pc); else passed++;
    drain(1);
    issue(4'b1110, 16'h7FFF, 16'h0050, 16'h0004);
    issue(4'b1111, 16'h7FFF, 16'h0100, 16'h0020);
    drain(0);
    issue(4'b1111, 16'h8001, 16'h0200, 16'h0001);
  endtask
  task automatic test_back_to_back();
    int acc = 0;
    in_valid = 1; in_inst_id = 4'b0000; in_result = '0;
    repeat (5) begin
      if (in_valid && in_ready) acc++;
      step();
    end
    in_valid = 0;
    total++; if (acc != 5) $display("FAIL b2b_accepts got %0d want 5", acc); else passed++;
    total++; if (branch_count !== exp_br || taken_count !== exp_tk || redirect_valid !== 1'b0)
      $display("FAIL b2b_counts got %h %h v=%b want %h %h 0", branch_count, taken_count, redirect_valid, exp_br, exp_tk); else passed++;
  endtask
  task automatic test_reset_mid_redirect();
    issue(4'b1100, 16'h0000, 16'h0300, 16'h0010);
    step();
    reset = 0;
    step();
    total++; if (redirect_valid !== 1'b0 || flush !== 1'b0 || redirect_pc !== '0)
      $display("FAIL mid_reset got v=%b f=%b pc=%h want 0 0 0", redirect_valid, flush, redirect_pc); else passed++;
    total++; if (branch_count !== '0 || taken_count !== '0)
      $display("FAIL mid_reset_cnt got %h %h want 0 0", branch_count, taken_count); else passed++;
    reset = 1;
    exp_q.delete(); exp_br = '0; exp_tk = '0;
    step();
    total++; if (in_ready !== 1'b1 || redirect_valid !== 1'b0 || flush !== 1'b0)
      $display("FAIL mid_reset_idle got r=%b v=%b f=%b want 1 0 0", in_ready, redirect_valid, flush); else passed++;
  endtask
  task automatic test_saturation();
    force dut.branch_count = 16'hFFFF;
    force dut.taken_count = 16'hFFFF;
    #1;
    release dut.branch_count;
    release dut.taken_count;
    exp_br = 16'hFFFF; exp_tk = 16'hFFFF;
    issue(4'b1100, 16'h0000, 16'h0400, 16'h0001);
    drain(0);
    force dut.taken_count = 16'h0005;
    #1;
    release dut.taken_count;
    exp_tk = 16'h0005;
    issue(4'b1110, 16'hF000, 16'h0500, 16'h0002);
    drain(0);
    issue(4'b1100, 16'h0001, 16'h0600, 16'h0002);
  endtask
  initial begin
    test_reset();
    test_beq();
    test_bne();
    test_blt_bge();
    test_back_to_back();
    test_reset_mid_redirect();
    test_saturation();
    total++; if (exp_q.size() != 0) $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
